wallace_cpa_pipe: RTL and testbench



---
 rtl/wallace_cpa_pipe.sv | 111 +++++++++++
 tb/tb_wallace_cpa_pipe.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/wallace_cpa_pipe.sv
// -----------------------------------------------------------------------------
// wallace_cpa_pipe
//
// Final carry-propagate adder of the Booth-4/Wallace 16x16 multiplier. It takes
// the two redundant rows from the compressor tree and resolves them into the
// product over two pipeline stages:
//   stage 1 : adds the low LO_W bits, keeps the carry-out and the raw high rows
//   stage 2 : adds the high rows plus the low carry, assembles the product
// Both sides use a valid/ready handshake so the consumer can stall the core.
//
// Ports
//   sys_clk     in   clock, all state updates on the rising edge
//   sys_rst_n   in   synchronous active-low reset
//   in_sum      in   sum row, aligned to product weight
//   in_carry    in   carry row, already shifted to its weight
//   in_valid    in   in_sum/in_carry hold a valid pair
//   in_ready    out  stage 1 can accept a pair this cycle
//   prod        out  (in_sum + in_carry) mod 2^WIDTH
//   prod_valid  out  prod holds a valid result
//   prod_ready  in   consumer accepts prod this cycle
// -----------------------------------------------------------------------------
module wallace_cpa_pipe #(
    parameter int WIDTH = 32,
    parameter int LO_W  = 16   // legal range 1..WIDTH-1
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic [WIDTH-1:0] in_sum,
    input  logic [WIDTH-1:0] in_carry,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] prod,
    output logic             prod_valid,
    input  logic             prod_ready
);

    localparam int HI_W = WIDTH - LO_W;

    // Stage 1 registers
    logic [LO_W-1:0] lo_sum_q;
    logic            lo_c_q;
    logic [HI_W-1:0] hi_a_q;
    logic [HI_W-1:0] hi_b_q;
    logic            s1_valid_q;

    // Stage 2 (output) registers
    logic [WIDTH-1:0] prod_q;
    logic             prod_valid_q;

    // Handshake
    logic in_xfer;
    logic out_xfer;
    logic s2_adv;

    // Datapath
    logic [LO_W:0]   lo_add;   // one extra bit to capture the carry-out
    logic [HI_W-1:0] hi_add;   // carry out of the top bit is dropped (mod 2^WIDTH)

    assign out_xfer = prod_valid_q & prod_ready;
    assign s2_adv   = s1_valid_q & (~prod_valid_q | prod_ready);
    // Depends only on registered state and prod_ready, never on in_valid, so
    // the upstream valid cannot form a combinational loop through this stage.
    assign in_ready = ~s1_valid_q | s2_adv;
    assign in_xfer  = in_valid & in_ready;

    assign lo_add = {1'b0, in_sum[LO_W-1:0]} + {1'b0, in_carry[LO_W-1:0]};
    assign hi_add = hi_a_q + hi_b_q + HI_W'(lo_c_q);

    // Stage 1: capture the low-half sum and the untouched high rows.
    always_ff @(posedge sys_clk) begin
        // NOTE: reset is synchronous -- sys_rst_n is only sampled on the clock
        // edge, so it is not in the sensitivity list. Every register here is
        // plain flops (no RAM), so clearing the data along with the valid bit
        // costs nothing and makes reset state fully deterministic.
        if (!sys_rst_n) begin
            lo_sum_q   <= '0;
            lo_c_q     <= 1'b0;
            hi_a_q     <= '0;
            hi_b_q     <= '0;
            s1_valid_q <= 1'b0;
        end else if (in_xfer) begin
            // NOTE: non-blocking assignments for all state so every register
            // samples pre-edge values regardless of statement order.
            lo_sum_q   <= lo_add[LO_W-1:0];
            lo_c_q     <= lo_add[LO_W];
            hi_a_q     <= in_sum[WIDTH-1:LO_W];
            hi_b_q     <= in_carry[WIDTH-1:LO_W];
            s1_valid_q <= 1'b1;
        end else if (s2_adv) begin
            s1_valid_q <= 1'b0;
        end
    end

    // Stage 2: resolve the high half and hold the product until consumed.
    // prod only changes on s2_adv, so it is stable throughout a stall.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            prod_q       <= '0;
            prod_valid_q <= 1'b0;
        end else if (s2_adv) begin
            prod_q       <= {hi_add, lo_sum_q};
            prod_valid_q <= 1'b1;
        end else if (out_xfer) begin
            prod_valid_q <= 1'b0;
        end
    end

    assign prod       = prod_q;
    assign prod_valid = prod_valid_q;

endmodule

// File: tb/tb_wallace_cpa_pipe.sv
// -----------------------------------------------------------------------------
// tb_wallace_cpa_pipe
//
// Directed bench for wallace_cpa_pipe. Every accepted pair pushes its expected
// product (sum + carry, mod 2^32) onto a scoreboard queue; every output
// transfer pops and compares. Directed steps add latency, stall and reset
// checks on top of the scoreboard.
// -----------------------------------------------------------------------------
module tb_wallace_cpa_pipe;

    localparam int WIDTH = 32;
    localparam int LO_W  = 16;

    logic             sys_clk;
    logic             sys_rst_n;
    logic [WIDTH-1:0] in_sum;
    logic [WIDTH-1:0] in_carry;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] prod;
    logic             prod_valid;
    logic             prod_ready;

    int checks = 0;
    int errors = 0;
    int accepted = 0;
    logic [WIDTH-1:0] sb_q[$];

    wallace_cpa_pipe #(.WIDTH(WIDTH), .LO_W(LO_W)) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .in_sum     (in_sum),
        .in_carry   (in_carry),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .prod       (prod),
        .prod_valid (prod_valid),
        .prod_ready (prod_ready)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                         input logic [WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic drive(input logic v, input logic [WIDTH-1:0] s,
                         input logic [WIDTH-1:0] c);
        in_valid = v;
        in_sum   = s;
        in_carry = c;
    endtask

    // Scoreboard: sampled on the falling edge, i.e. the values the next rising
    // edge will act on. Pop before push so a same-cycle accept never matches
    // its own output.
    always @(negedge sys_clk) begin
        if (!sys_rst_n) begin
            sb_q.delete();
        end else begin
            if (prod_valid === 1'b1 && prod_ready === 1'b1) begin
                if (sb_q.size() == 0)
                    check("sb_unexpected_output", {31'b0, prod_valid}, '0);
                else
                    check("sb_prod", prod, sb_q.pop_front());
            end
            if (in_valid === 1'b1 && in_ready === 1'b1) begin
                sb_q.push_back(in_sum + in_carry);
                accepted++;
            end
        end
    end

    initial begin
        logic [WIDTH-1:0] s;
        logic [WIDTH-1:0] c;
        logic [WIDTH-1:0] held;
        int acc0;

        sys_rst_n  = 1'b0;
        prod_ready = 1'b1;
        drive(1'b0, '0, '0);

        // ---- reset state ----
        step(2);
        check("rst_prod_valid", {31'b0, prod_valid}, '0);
        check("rst_prod", prod, '0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        sys_rst_n = 1'b1;
        step(1);

        // ---- basic low-half carry, latency 2 ----
        drive(1'b1, 32'h0000_FFFF, 32'h0000_0001);
        step(1);                                   // accepted at this edge
        drive(1'b0, '0, '0);
        check("lat_not_yet", {31'b0, prod_valid}, '0);
        step(1);
        check("lat_valid", {31'b0, prod_valid}, 32'd1);
        check("lo_carry_prod", prod, 32'h0001_0000);
        step(1);
        check("lat_drained", {31'b0, prod_valid}, '0);

        // ---- wrap: carry out of bit 31 discarded ----
        drive(1'b1, 32'hFFFF_FFFF, 32'h0000_0001);
        step(1);
        drive(1'b0, '0, '0);
        step(1);
        check("wrap_prod", prod, 32'h0000_0000);
        check("wrap_valid", {31'b0, prod_valid}, 32'd1);

        // ---- full products, rows split so both halves carry ----
        c = 32'h1555_5554;
        s = 32'h3FFF_0001 - c;
        drive(1'b1, s, c);
        step(1);
        c = 32'h1555_5555;
        s = 32'h4000_0000 - c;
        drive(1'b1, s, c);
        step(1);
        drive(1'b0, '0, '0);
        check("mul_7fff_sq", prod, 32'h3FFF_0001);
        step(1);
        check("mul_8000_sq", prod, 32'h4000_0000);
        step(1);

        // ---- back-to-back: 8 pairs, one result per cycle ----
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, $urandom(), $urandom());
            check($sformatf("b2b_in_ready_%0d", i), {31'b0, in_ready}, 32'd1);
            step(1);
            if (i > 0)
                check($sformatf("b2b_valid_%0d", i), {31'b0, prod_valid}, 32'd1);
        end
        drive(1'b0, '0, '0);
        step(1);
        check("b2b_last_valid", {31'b0, prod_valid}, 32'd1);
        step(1);
        check("b2b_drained", {31'b0, prod_valid}, '0);

        // ---- backpressure: prod_ready low for 5 edges, 3 pairs offered ----
        acc0       = accepted;
        prod_ready = 1'b0;
        drive(1'b1, 32'h1234_8000, 32'h0001_8000);   // P0 -> 0x1236_0000
        step(1);
        check("bp_e1_in_ready", {31'b0, in_ready}, 32'd1);
        drive(1'b1, 32'h0000_0010, 32'h0000_0020);   // P1 -> 0x0000_0030
        step(1);
        check("bp_e2_valid", {31'b0, prod_valid}, 32'd1);
        check("bp_e2_prod", prod, 32'h1236_0000);
        check("bp_e2_in_ready", {31'b0, in_ready}, '0);
        held = 32'h1236_0000;
        drive(1'b1, 32'hA5A5_A5A5, 32'h5A5A_5A5B);   // P2 -> 0x0000_0000
        for (int e = 3; e <= 5; e++) begin
            step(1);
            check($sformatf("bp_e%0d_prod_stable", e), prod, held);
            check($sformatf("bp_e%0d_valid", e), {31'b0, prod_valid}, 32'd1);
            check($sformatf("bp_e%0d_in_ready", e), {31'b0, in_ready}, '0);
        end
        check("bp_accept_count", 32'(accepted - acc0), 32'd2);
        prod_ready = 1'b1;
        step(1);                                      // P0 out, P2 accepted
        drive(1'b0, '0, '0);
        check("bp_accept_third", 32'(accepted - acc0), 32'd3);
        check("bp_release_prod", prod, 32'h0000_0030);
        step(1);
        check("bp_third_prod", prod, 32'h0000_0000);
        step(2);
        check("bp_drained", {31'b0, prod_valid}, '0);

        // ---- reset mid-flight: two pairs in the pipe are discarded ----
        prod_ready = 1'b0;
        drive(1'b1, 32'h0000_1111, 32'h0000_2222);
        step(1);
        drive(1'b1, 32'h0000_3333, 32'h0000_4444);
        step(1);
        drive(1'b0, '0, '0);
        sys_rst_n = 1'b0;
        step(1);
        sys_rst_n = 1'b1;
        check("mid_rst_valid", {31'b0, prod_valid}, '0);
        check("mid_rst_prod", prod, '0);
        check("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
        prod_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step(1);
            check($sformatf("mid_rst_quiet_%0d", k), {31'b0, prod_valid}, '0);
        end

        // ---- everything accepted came out ----
        check("sb_empty_at_end", 32'(sb_q.size()), '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
